// File: rtl/game_flow_pkg.sv
// game_flow_pkg: state encoding, attract LFSR constants and screen images for the game-flow controller
package game_flow_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, PAUSE = 3'd2, LVLUP = 3'd3, WIN = 3'd4, LOSE = 3'd5} flow_state_t;
  typedef logic [7:0][23:0] image_t;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] SEED_BASE = 32'h1D87_2B41;
  localparam logic [31:0] SEED_STEP = 32'h0101_0101;
  localparam logic [23:0] DIM_MASK = 24'h924924;
  function automatic image_t banner_img(input int n);
    for (int r = 0; r < 8; r++)
      banner_img[r] = (r == 0 || r == 7) ? 24'h249249 : 24'h492492 & ~(24'hFFFFFF << (3 * (n + 1)));
  endfunction
  localparam image_t SMILE = {24'h000000, 24'h036D80, 24'h0C0060, 24'h300018, 24'h000000, 24'h0C0300, 24'h0C0300, 24'h000000};
  localparam image_t FROWN = {24'h000000, 24'h300018, 24'h0C0060, 24'h036D80, 24'h000000, 24'h0C0300, 24'h0C0300, 24'h000000};
  localparam image_t [7:0] BANNER = {banner_img(7), banner_img(6), banner_img(5), banner_img(4),
                                     banner_img(3), banner_img(2), banner_img(1), banner_img(0)};
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
  function automatic logic [31:0] lfsr_seed(input int r);
    return SEED_BASE + 32'(r) * SEED_STEP;
  endfunction
  function automatic logic [23:0] img_row(input image_t img, input int r);
    return r < 8 ? img[r[2:0]] : 24'h0;
  endfunction
endpackage

// File: rtl/attract_lfsr.sv
// attract_lfsr: one 32-bit Galois LFSR per row, low W bits form the attract frame
module attract_lfsr import game_flow_pkg::*; #(
  parameter int ROWS = 8,
  parameter int W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                reseed,
  input  logic                step,
  output logic [ROWS-1:0][W-1:0] frame
);
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    logic [31:0] s;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) s <= lfsr_seed(g);
      else if (reseed) s <= lfsr_seed(g);
      else if (step) s <= lfsr_step(s);
    assign frame[g] = s[W-1:0];
  end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: attract/play/pause/level-up/win/lose sequencer with frame tick and output frame select
module game_flow_ctrl import game_flow_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int TICK_DIV = 8_000_000,
  parameter int LEVELS = 4,
  parameter int RESULT_TICKS = 40,
  parameter int BANNER_TICKS = 16,
  localparam int W = COLS * 3,
  localparam int LW = LEVELS > 1 ? $clog2(LEVELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   end_game,
  input  logic                   game_completed,
  input  logic [ROWS-1:0][W-1:0] play_frame,
  output logic                   act,
  output logic                   game_reset,
  output logic                   tick,
  output logic [LW-1:0]          level,
  output logic [2:0]             state_o,
  output logic [ROWS-1:0][W-1:0] out
);
  localparam int CW = $clog2(TICK_DIV);
  flow_state_t state, state_n;
  logic [LW-1:0] level_n;
  logic [CW-1:0] cnt;
  logic [31:0] hold;
  logic start_q, pause_q, armed, start_rise, pause_rise, hold_done, new_round;
  logic [2:0] bidx;
  logic [ROWS-1:0][W-1:0] attract, frame_d;
  // armed keeps a button held through reset release from looking like a fresh press
  assign start_rise = armed & start & ~start_q;
  assign pause_rise = armed & pause & ~pause_q;
  assign tick = state != PAUSE && cnt == CW'(TICK_DIV - 1);
  assign hold_done = tick && hold == 32'((state == LVLUP ? BANNER_TICKS : RESULT_TICKS) - 1);
  assign bidx = 3'(32'(level) + 1);

  attract_lfsr #(.ROWS(ROWS), .W(W)) u_attract (
    .clk    (clk),
    .reset_n(reset_n),
    .reseed (state_n == IDLE && state != IDLE),
    .step   (tick && state == IDLE),
    .frame  (attract)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      level <= '0;
      game_reset <= 1'b0;
      cnt <= '0;
      hold <= '0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      armed <= 1'b0;
      out <= '0;
    end else begin
      state <= state_n;
      level <= level_n;
      game_reset <= new_round;
      cnt <= new_round || tick ? '0 : state == PAUSE ? cnt : cnt + CW'(1);
      hold <= state_n != state ? '0 : hold + 32'(tick);
      start_q <= start;
      pause_q <= pause;
      armed <= 1'b1;
      out <= frame_d;
    end

  always_comb begin
    state_n = state;
    level_n = level;
    new_round = 1'b0;
    case (state)
      IDLE: if (start_rise) begin
        state_n = PLAY;
        level_n = '0;
        new_round = 1'b1;
      end
      PLAY: if (end_game) state_n = !game_completed ? LOSE : level == LW'(LEVELS - 1) ? WIN : LVLUP;
            else if (pause_rise) state_n = PAUSE;
      PAUSE: state_n = start_rise ? IDLE : pause_rise ? PLAY : PAUSE;
      LVLUP: if (hold_done || start_rise) begin
        state_n = PLAY;
        level_n = level + LW'(1);
        new_round = 1'b1;
      end
      WIN, LOSE: if (hold_done || start_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    act = state == PLAY;
    state_o = state;
    for (int r = 0; r < ROWS; r++)
      frame_d[r] = state == IDLE  ? attract[r] :
                   state == PLAY  ? play_frame[r] :
                   state == PAUSE ? play_frame[r] & W'(DIM_MASK) :
                   W'(img_row(state == LVLUP ? BANNER[bidx] : state == WIN ? SMILE : FROWN, r));
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: scenario tasks driving game_flow_ctrl, output frames checked through an expected-frame queue
module tb_game_flow_ctrl;
  import game_flow_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, pause = 1'b0, end_game = 1'b0, game_completed = 1'b0;
  image_t play_frame = '0;
  logic act, game_reset, tick, level;
  logic [2:0] state_o;
  image_t out, e;
  image_t exp_q[$];
  int total = 0, bad = 0;

  game_flow_ctrl #(.ROWS(8), .COLS(8), .TICK_DIV(4), .LEVELS(2), .RESULT_TICKS(3), .BANNER_TICKS(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .end_game(end_game),
    .game_completed(game_completed), .play_frame(play_frame), .act(act), .game_reset(game_reset),
    .tick(tick), .level(level), .state_o(state_o), .out(out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic image_t seed_frame;
    for (int r = 0; r < 8; r++) seed_frame[r] = 24'(32'h1D872B41 + 32'(r) * 32'h01010101);
  endfunction

  function automatic image_t galois_frame(input int steps);
    logic [31:0] x;
    for (int r = 0; r < 8; r++) begin
      x = 32'h1D872B41 + 32'(r) * 32'h01010101;
      for (int k = 0; k < steps; k++) x = (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
      galois_frame[r] = x[23:0];
    end
  endfunction

  function automatic image_t dimmed(input image_t f);
    for (int r = 0; r < 8; r++) dimmed[r] = f[r] & 24'h924924;
  endfunction

  task automatic test_reset;
    int errs = 0;
    reset_n = 1'b0;
    start = 1'b1;
    #3;
    total++;
    if (state_o !== 3'd0 || act !== 1'b0 || game_reset !== 1'b0 || tick !== 1'b0 || level !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: state=%0d act=%b gr=%b tick=%b lvl=%b, want all 0", state_o, act, game_reset, tick, level);
    end
    total++;
    if (out !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", out); end
    step;
    step;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      if (state_o !== 3'd0 || game_reset !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL start_held_reset: %0d cycles left IDLE, want 0", errs); end
  endtask

  task automatic test_start;
    play_frame = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start = 1'b0;
    step;
    start = 1'b1;
    step;
    start = 1'b0;
    total++;
    if (state_o !== 3'd1 || game_reset !== 1'b1 || level !== 1'b0 || act !== 1'b1) begin
      bad++;
      $display("FAIL start_play: state=%0d gr=%b lvl=%b act=%b, want 1 1 0 1", state_o, game_reset, level, act);
    end
    exp_q.push_back(play_frame);
    step;
    e = exp_q.pop_front();
    total++;
    if (out !== e) begin bad++; $display("FAIL play_out: got %h want %h", out, e); end
    total++;
    if (game_reset !== 1'b0) begin bad++; $display("FAIL game_reset_width: got %b want 0", game_reset); end
    for (int i = 2; i < 10; i++) begin
      step;
      total++;
      if (tick !== (i % 4 == 3)) begin bad++; $display("FAIL tick_period cyc%0d: got %b want %b", i, tick, i % 4 == 3); end
    end
  endtask

  task automatic test_lvlup;
    int ticks = 0, n = 0;
    end_game = 1'b1;
    game_completed = 1'b1;
    step;
    end_game = 1'b0;
    game_completed = 1'b0;
    total++;
    if (state_o !== 3'd3 || act !== 1'b0) begin bad++; $display("FAIL lvlup_enter: state=%0d act=%b want 3 0", state_o, act); end
    while (state_o === 3'd3 && n < 40) begin
      ticks += int'(tick);
      exp_q.push_back(BANNER[1]);
      step;
      e = exp_q.pop_front();
      total++;
      if (out !== e) begin bad++; $display("FAIL banner_out: got %h want %h", out, e); end
      n++;
    end
    total++;
    if (state_o !== 3'd1 || level !== 1'b1 || game_reset !== 1'b1) begin
      bad++;
      $display("FAIL lvlup_exit: state=%0d lvl=%b gr=%b want 1 1 1", state_o, level, game_reset);
    end
    total++;
    if (ticks !== 2) begin bad++; $display("FAIL lvlup_ticks: got %0d want 2", ticks); end
  endtask

  task automatic test_win;
    int ticks = 0, n = 0;
    end_game = 1'b1;
    game_completed = 1'b1;
    step;
    end_game = 1'b0;
    game_completed = 1'b0;
    total++;
    if (state_o !== 3'd4) begin bad++; $display("FAIL win_enter: state=%0d want 4", state_o); end
    while (state_o === 3'd4 && n < 40) begin
      ticks += int'(tick);
      exp_q.push_back(SMILE);
      step;
      e = exp_q.pop_front();
      total++;
      if (out !== e) begin bad++; $display("FAIL smile_out: got %h want %h", out, e); end
      n++;
    end
    total++;
    if (state_o !== 3'd0 || ticks !== 3) begin bad++; $display("FAIL win_exit: state=%0d ticks=%0d want 0 3", state_o, ticks); end
    exp_q.push_back(seed_frame());
    step;
    e = exp_q.pop_front();
    total++;
    if (out !== e) begin bad++; $display("FAIL attract_seed: got %h want %h", out, e); end
    n = 0;
    while (tick !== 1'b1 && n < 8) begin step; n++; end
    total++;
    if (tick !== 1'b1) begin bad++; $display("FAIL attract_tick_timeout: tick=%b want 1", tick); end
    exp_q.push_back(galois_frame(1));
    step;
    step;
    e = exp_q.pop_front();
    total++;
    if (out !== e) begin bad++; $display("FAIL attract_step: got %h want %h", out, e); end
  endtask

  task automatic test_pause;
    int ticks = 0, n = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    total++;
    if (state_o !== 3'd1 || level !== 1'b0) begin bad++; $display("FAIL restart: state=%0d lvl=%b want 1 0", state_o, level); end
    play_frame = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pause = 1'b1;
    step;
    pause = 1'b0;
    total++;
    if (state_o !== 3'd2 || act !== 1'b0) begin bad++; $display("FAIL pause_enter: state=%0d act=%b want 2 0", state_o, act); end
    for (int i = 0; i < 20; i++) begin
      if (i == 10) play_frame = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ticks += int'(tick);
      exp_q.push_back(dimmed(play_frame));
      step;
      e = exp_q.pop_front();
      total++;
      if (out !== e) begin bad++; $display("FAIL dim_out cyc%0d: got %h want %h", i, out, e); end
    end
    total++;
    if (ticks !== 0) begin bad++; $display("FAIL pause_tick: got %0d ticks want 0", ticks); end
    pause = 1'b1;
    step;
    pause = 1'b0;
    total++;
    if (state_o !== 3'd1 || act !== 1'b1) begin bad++; $display("FAIL pause_exit: state=%0d act=%b want 1 1", state_o, act); end
    while (tick !== 1'b1 && n < 3) begin step; n++; end
    total++;
    if (tick !== 1'b1) begin bad++; $display("FAIL resume_tick: tick=%b after %0d cycles want 1", tick, n); end
  endtask

  task automatic test_abort;
    pause = 1'b1;
    step;
    pause = 1'b0;
    total++;
    if (state_o !== 3'd2) begin bad++; $display("FAIL abort_pause: state=%0d want 2", state_o); end
    step;
    start = 1'b1;
    pause = 1'b1;
    step;
    start = 1'b0;
    pause = 1'b0;
    total++;
    if (state_o !== 3'd0) begin bad++; $display("FAIL abort_idle: state=%0d want 0", state_o); end
    exp_q.push_back(seed_frame());
    step;
    e = exp_q.pop_front();
    total++;
    if (out !== e) begin bad++; $display("FAIL abort_reseed: got %h want %h", out, e); end
  endtask

  task automatic test_lose_reset;
    int errs = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    end_game = 1'b1;
    game_completed = 1'b0;
    pause = 1'b1;
    step;
    end_game = 1'b0;
    pause = 1'b0;
    total++;
    if (state_o !== 3'd5) begin bad++; $display("FAIL lose_priority: state=%0d want 5", state_o); end
    exp_q.push_back(FROWN);
    step;
    e = exp_q.pop_front();
    total++;
    if (out !== e) begin bad++; $display("FAIL frown_out: got %h want %h", out, e); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (out !== '0 || state_o !== 3'd0 || act !== 1'b0 || game_reset !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: out=%h state=%0d act=%b gr=%b want 0", out, state_o, act, game_reset);
    end
    step;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      if (game_reset !== 1'b0 || state_o !== 3'd0) errs++;
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL reset_no_pulse: %0d bad cycles want 0", errs); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_lvlup;
    test_win;
    test_pause;
    test_abort;
    test_lose_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised top-level game-flow controller for the LED-matrix game engine. It sequences attract mode, play, pause, level-up, win and lose screens. It generates the engine frame tick and the one-cycle game-reset pulse, and selects which frame drives the matrix output. It sits between the button/debounce logic and the display driver, and supervises the play engine through `act`, `game_reset` and `tick`.

## Interface
- `ROWS`, 8, matrix rows
- `COLS`, 8, matrix columns; row word is `COLS*3` bits (RGB, 1 bit per channel); `COLS*3` ≤ 32
- `TICK_DIV`, 8_000_000, clk cycles per frame tick (≥ 2)
- `LEVELS`, 4, levels to clear before WIN (≥ 1)
- `RESULT_TICKS`, 40, ticks a WIN/LOSE screen holds before returning to attract
- `BANNER_TICKS`, 16, ticks the level-up banner holds
- `clk` in 1: single clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: start/restart button, level (debounced upstream)
- `pause` in 1: pause button, level
- `end_game` in 1: play engine reports the round is over
- `game_completed` in 1: qualifies `end_game`; 1 = level cleared, 0 = lost
- `play_frame` in `ROWS`×`COLS*3`: frame from the play engine
- `act` out 1: play engine may advance (state PLAY)
- `game_reset` out 1: one-cycle pulse that reinitialises the play engine
- `tick` out 1: one-cycle frame tick
- `level` out `$clog2(LEVELS)` (min 1): current level, 0-based
- `state_o` out 3: current state encoding
- `out` out `ROWS`×`COLS*3`: registered frame to the display driver

## Operation
- `start_rise`/`pause_rise` come from registered previous values: `x & ~x_q`. All transitions use rising edges only.
- Tick divider: counter `0..TICK_DIV-1`. `tick` = 1 for the cycle where the counter equals `TICK_DIV-1`. The counter is frozen in PAUSE and cleared on every `game_reset`.
- States are IDLE, PLAY, PAUSE, LVLUP, WIN, LOSE.
- **IDLE** (attract): `out` shows the attract generator frame, which advances on `tick`.
  - `start_rise` → PLAY with `level`=0 and a `game_reset` pulse.
- **PLAY**: `act`=1, `out` = `play_frame`. Priority order:
  - `end_game`: if `game_completed`=0 → LOSE; else if `level`==`LEVELS-1` → WIN; else → LVLUP.
  - `pause_rise` → PAUSE.
  - `start_rise` is ignored.
- **PAUSE**: `act`=0, `out` = `play_frame` with every row ANDed with `DIM_MASK`, tick frozen.
  - `pause_rise` → PLAY.
  - `start_rise` → IDLE (abort; takes priority over `pause_rise`).
- **LVLUP**: `out` = `BANNER[level+1]`. Counts `BANNER_TICKS` ticks, or ends early on `start_rise`.
  - On exit → PLAY with `level`+1 and a `game_reset` pulse.
- **WIN/LOSE**: `out` = `SMILE`/`FROWN`. After `RESULT_TICKS` ticks, or on `start_rise` → IDLE.
- Hold counter (shared by LVLUP, WIN, LOSE): cleared on state entry, increments on `tick`. Exit when count == limit−1 and `tick`=1.
- Attract generator: one 32-bit Galois LFSR per row, polynomial `LFSR_POLY`, seeded `SEED_BASE + r*SEED_STEP`.
  - Steps on `tick` in IDLE only; row word = low `COLS*3` bits.
  - Reseeded on `reset_n` and on entry to IDLE.

## Timing
- `out` is registered and reflects the state and sources of the previous cycle (1-cycle latency).
- State, `act` and `state_o` change on the edge after the qualifying input.
- `game_reset` is high exactly one cycle, concurrent with the first PLAY cycle.
- Reset values: state IDLE, `act` 0, `game_reset` 0, `tick` 0, `level` 0, `out` all zero, all counters 0, LFSRs at seed, edge-detect registers 0.
  - `start` held high through reset release must not trigger PLAY.
- `end_game` asserted together with `pause_rise` → `end_game` wins.
- `reset_n` asserted mid-game → immediate IDLE; no `game_reset` pulse is generated.

## Structure
- Package `game_flow_pkg` holds:
  - state enum `flow_state_t` (IDLE=0, PLAY=1, PAUSE=2, LVLUP=3, WIN=4, LOSE=5)
  - `LFSR_POLY`=32'h8020_0003, `SEED_BASE`=32'h1D87_2B41, `SEED_STEP`=32'h0101_0101
  - `DIM_MASK`=24'h924924 (red only)
  - `SMILE`, `FROWN`, and `BANNER[0..7]` 8×24 constants
- One sub-module `attract_lfsr` (params `ROWS`, `W`) generates the attract frame.

## Test plan
Parameters for the bench: `TICK_DIV`=4, `LEVELS`=2, `RESULT_TICKS`=3, `BANNER_TICKS`=2.
1. Reset with `start`=1, release, keep `start` high for 10 cycles → state stays IDLE. Then `start` 0→1 → PLAY next edge, `game_reset` high 1 cycle, `level`=0.
2. In PLAY, pulse `end_game`=1 with `game_completed`=1 → LVLUP. `out`=`BANNER[1]` after 1 cycle. After 2 ticks (8 cycles) → PLAY, `level`=1, `game_reset` pulse.
3. At `level`=1, `end_game` with `game_completed`=1 → WIN, `out`=`SMILE`. After 3 ticks → IDLE, `out` = LFSR seed frame.
4. In PLAY, `pause_rise` → PAUSE, `act`=0, `tick` silent for 20 cycles, `out`=`play_frame` & `DIM_MASK`. Second `pause_rise` → PLAY, and the first tick arrives within 4 cycles.
5. In PAUSE, `start_rise` and `pause_rise` on the same cycle → IDLE.
6. In PLAY, `end_game`=1 with `game_completed`=0 and `pause_rise` on the same cycle → LOSE, `out`=`FROWN`. Assert `reset_n`=0 mid-screen → `out`=0 and state IDLE asynchronously.
